// File: rtl/fast9_corner_eval.sv
// fast9_corner_eval
//   Collects one FAST-9 candidate (centre + 16 Bresenham circle pixels) from
//   the address/sequence controller, classifies it as a bright or dark corner
//   in a two-stage pipeline and queues results in a small valid/ready FIFO.
//
//   Ports
//     clock, nReset      rising-edge clock, async active-low reset
//     pix_valid/idx/data slot write: idx 0 = centre, 1..16 = circle clockwise
//     pix_last           closes the candidate (comes with slot 16)
//     pix_addr, thr      centre address / FAST threshold, sampled on pix_last
//     out_valid/ready    FIFO head handshake
//     out_addr/corner/dark  head entry fields
//     overflow           sticky: a push was dropped on a full FIFO
//     incomplete         sticky: pix_last seen before all 17 slots written

// Per-circle-position threshold test. One extra bit of headroom so c + thr
// and p + thr never wrap.
module fast9_cmp #(
  parameter int PIX_W = 8
) (
  input  logic [PIX_W-1:0] p_i,
  input  logic [PIX_W-1:0] c_i,
  input  logic [PIX_W-1:0] thr_i,
  output logic             bright_o,
  output logic             dark_o
);
  logic [PIX_W:0] p_x, c_x, t_x;
  assign p_x      = {1'b0, p_i};
  assign c_x      = {1'b0, c_i};
  assign t_x      = {1'b0, thr_i};
  assign bright_o = p_x > (c_x + t_x);
  assign dark_o   = (p_x + t_x) < c_x;
endmodule

module fast9_corner_eval #(
  parameter int PIX_W      = 8,
  parameter int ADDR_W     = 15,
  parameter int ARC_LEN    = 9,
  parameter int FIFO_DEPTH = 4,
  parameter int EMIT_ALL   = 0
) (
  input  logic              clock,
  input  logic              nReset,
  input  logic              pix_valid,
  input  logic [4:0]        pix_idx,
  input  logic [PIX_W-1:0]  pix_data,
  input  logic              pix_last,
  input  logic [ADDR_W-1:0] pix_addr,
  input  logic [PIX_W-1:0]  thr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_corner,
  output logic              out_dark,
  output logic              overflow,
  output logic              incomplete
);
  localparam int NSLOT  = 17;
  localparam int NCIRC  = 16;
  localparam int STAGES = 2;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              corner;
    logic              dark;
  } res_t;

  // ---------------- capture ----------------
  logic [NSLOT-1:0][PIX_W-1:0] slot_q, slot_fwd;
  logic [NSLOT-1:0]            loaded_q, loaded_d, wr_mask;
  logic                        wr_en, close, all_ld, launch;

  assign wr_en = pix_valid && (pix_idx <= 5'd16);

  // slot_fwd is the slot file with this cycle's write applied, so the
  // closing slot-16 value feeds the comparators without a cycle of delay.
  always_comb begin
    wr_mask  = '0;
    slot_fwd = slot_q;
    if (wr_en) begin
      wr_mask[pix_idx]  = 1'b1;
      slot_fwd[pix_idx] = pix_data;
    end
  end

  assign close    = pix_valid & pix_last;
  assign all_ld   = &(loaded_q | wr_mask);
  assign launch   = close & all_ld;
  assign loaded_d = close ? '0 : (loaded_q | wr_mask);

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      slot_q   <= '0;
      loaded_q <= '0;
    end else begin
      slot_q   <= slot_fwd;
      loaded_q <= loaded_d;
    end
  end

  // ---------------- stage 1: bright/dark masks ----------------
  logic [NCIRC-1:0] bright_c, dark_c;

  for (genvar i = 0; i < NCIRC; i++) begin : g_cmp
    fast9_cmp #(.PIX_W(PIX_W)) u_cmp (
      .p_i      (slot_fwd[i+1]),
      .c_i      (slot_fwd[0]),
      .thr_i    (thr),
      .bright_o (bright_c[i]),
      .dark_o   (dark_c[i])
    );
  end

  logic [STAGES:1]   vld_pipe_q;
  logic [NCIRC-1:0]  bright_q, dark_q;
  logic [ADDR_W-1:0] addr1_q, addr2_q;
  logic              corner2_q, dark2_q;
  logic              arc_b, arc_d;

  // Circular run test: some start position has ARC_LEN consecutive ones,
  // wrapping from position 16 back to position 1.
  function automatic logic has_arc(input logic [NCIRC-1:0] m);
    logic hit, run;
    hit = 1'b0;
    for (int s = 0; s < NCIRC; s++) begin
      run = 1'b1;
      for (int k = 0; k < ARC_LEN; k++) run = run & m[(s + k) % NCIRC];
      hit = hit | run;
    end
    return hit;
  endfunction

  assign arc_b = has_arc(bright_q);
  assign arc_d = has_arc(dark_q);

  // ---------------- stage 2: classification ----------------
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      vld_pipe_q <= '0;
      bright_q   <= '0;
      dark_q     <= '0;
      addr1_q    <= '0;
      corner2_q  <= 1'b0;
      dark2_q    <= 1'b0;
      addr2_q    <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[STAGES-1:1], launch};
      if (launch) begin
        bright_q <= bright_c;
        dark_q   <= dark_c;
        addr1_q  <= pix_addr;
      end
      if (vld_pipe_q[1]) begin
        corner2_q <= arc_b | arc_d;
        dark2_q   <= arc_d & ~arc_b;   // bright wins if both ever fire
        addr2_q   <= addr1_q;
      end
    end
  end

  // ---------------- output FIFO ----------------
  res_t             mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             full, pop, push_req, push_ok, overflow_q, incomplete_q;
  res_t             push_ent;

  assign push_ent = '{addr: addr2_q, corner: corner2_q, dark: dark2_q};
  assign push_req = vld_pipe_q[STAGES] & (corner2_q | (EMIT_ALL != 0));
  assign full     = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign out_valid = (cnt_q != '0);
  assign pop      = out_valid & out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok  = push_req & (~full | pop);

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      cnt_q        <= '0;
      overflow_q   <= 1'b0;
      incomplete_q <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_ent;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q <= cnt_q + CNT_W'(push_ok) - CNT_W'(pop);
      if (push_req && !push_ok) overflow_q <= 1'b1;
      if (close && !all_ld) incomplete_q <= 1'b1;
    end
  end

  assign out_addr   = mem_q[rd_ptr_q].addr;
  assign out_corner = mem_q[rd_ptr_q].corner;
  assign out_dark   = mem_q[rd_ptr_q].dark;
  assign overflow   = overflow_q;
  assign incomplete = incomplete_q;

endmodule
